// File: rtl/dpc_pkg.sv
// Shared constants and parameter checks for the DPC pipeline.
// Imported by every dpc_* module.
package dpc_pkg;

  localparam int RAW_CIIW_DEF  = 10;
  localparam int DPC_HCORR_LAT = 2;

  function automatic bit px_rate_ok(input int n);
    return (n == 2) || (n == 4);
  endfunction

endpackage

// File: rtl/dpc_px_judge.sv
// Per-pixel hot/cold test against two same-colour neighbours.
// Purely combinational; replacement is the rounded neighbour mean.
module dpc_px_judge
  import dpc_pkg::*;
#(
  parameter int W = RAW_CIIW_DEF
) (
  input  logic [W-1:0] i_p,
  input  logic [W-1:0] i_l,
  input  logic [W-1:0] i_r,
  input  logic [W-1:0] i_thr,
  input  logic         i_en,
  output logic [W-1:0] o_px,
  output logic         o_corr
);

  logic [W:0] w_mx;
  logic [W:0] w_mn;
  logic [W:0] w_hi;
  logic [W:0] w_lo;
  logic [W:0] w_sum;
  logic       w_hot;
  logic       w_cold;

  // One extra bit so thresholds never wrap.
  always_comb begin
    w_mx   = (i_l > i_r) ? {1'b0, i_l} : {1'b0, i_r};
    w_mn   = (i_l > i_r) ? {1'b0, i_r} : {1'b0, i_l};
    w_hi   = w_mx + {1'b0, i_thr};
    w_lo   = {1'b0, i_p} + {1'b0, i_thr};
    w_hot  = {1'b0, i_p} > w_hi;
    w_cold = w_lo < w_mn;
    w_sum  = {1'b0, i_l} + {1'b0, i_r} + {{W{1'b0}}, 1'b1};
    o_corr = i_en & (w_hot | w_cold);
    o_px   = o_corr ? w_sum[W:1] : i_p;
  end

endmodule

// File: rtl/dpc_hor_corr.sv
// Horizontal single-line defect pixel corrector, multi-pixel beats.
// Fixed 2-cycle latency; per-frame correction count latched at i_fstr.
module dpc_hor_corr
  import dpc_pkg::*;
#(
  parameter int RAW_CIIW = RAW_CIIW_DEF,
  parameter int PX_RATE  = 2,
  parameter int PX_WD    = RAW_CIIW * PX_RATE,
  parameter int CNT_WTH  = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [PX_WD-1:0]    i_raw_data,
  input  logic                i_data_vld,
  input  logic                i_hstr,
  input  logic                i_hend,
  input  logic                i_fstr,
  input  logic                r_dpc_en,
  input  logic [RAW_CIIW-1:0] r_thr,
  output logic [PX_WD-1:0]    o_data,
  output logic                o_dvld,
  output logic                o_hstr,
  output logic                o_hend,
  output logic [CNT_WTH-1:0]  o_frm_corr_cnt
);

  localparam int W = RAW_CIIW;

  if (!px_rate_ok(PX_RATE)) begin : g_bad_rate
    $error("dpc_hor_corr: PX_RATE must be 2 or 4");
  end

  logic               r_inl;
  logic [2*W-1:0]     r_prev;
  logic [PX_WD-1:0]   r_cur;
  logic               r_cur_vld;
  logic               r_cur_hstr;
  logic               r_cur_hend;
  logic [CNT_WTH-1:0] r_run;

  logic               w_acc;
  logic [PX_WD-1:0]   w_out;
  logic [PX_RATE-1:0] w_corr;
  logic [2:0]         w_ncnt;
  logic [CNT_WTH:0]   w_run_nx;
  logic [CNT_WTH-1:0] w_sum;

  // Beats outside a line that began with hstr are dropped.
  assign w_acc = i_data_vld & (i_hstr | r_inl);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_inl      <= 1'b0;
      r_prev     <= '0;
      r_cur      <= '0;
      r_cur_vld  <= 1'b0;
      r_cur_hstr <= 1'b0;
      r_cur_hend <= 1'b0;
    end else begin
      r_cur_vld <= w_acc;
      if (w_acc) begin
        r_inl      <= ~i_hend;
        r_prev     <= r_cur[PX_WD-1 -: 2*W];
        r_cur      <= i_raw_data;
        r_cur_hstr <= i_hstr;
        r_cur_hend <= i_hend;
      end
    end
  end

  for (genvar j = 0; j < PX_RATE; j++) begin : g_lane
    localparam bit LEFT_EDGE  = (j < 2);
    localparam bit RIGHT_EDGE = (j >= PX_RATE - 2);

    logic [W-1:0] w_p;
    logic [W-1:0] w_lraw;
    logic [W-1:0] w_rraw;
    logic [W-1:0] w_l;
    logic [W-1:0] w_r;
    logic         w_lmiss;
    logic         w_rmiss;

    assign w_p = r_cur[j*W +: W];

    if (j >= 2) begin : g_lc
      assign w_lraw = r_cur[(j-2)*W +: W];
    end else begin : g_lp
      assign w_lraw = r_prev[j*W +: W];
    end

    if (j + 2 < PX_RATE) begin : g_rc
      assign w_rraw = r_cur[(j+2)*W +: W];
    end else begin : g_rn
      assign w_rraw = i_raw_data[(j+2-PX_RATE)*W +: W];
    end

    // Mirror the surviving neighbour at line edges.
    assign w_lmiss = r_cur_hstr & LEFT_EDGE;
    assign w_rmiss = r_cur_hend & RIGHT_EDGE;
    assign w_l     = w_lmiss ? w_rraw : w_lraw;
    assign w_r     = w_rmiss ? w_lraw : w_rraw;

    dpc_px_judge #(
      .W (W)
    ) u_judge (
      .i_p    (w_p),
      .i_l    (w_l),
      .i_r    (w_r),
      .i_thr  (r_thr),
      .i_en   (r_dpc_en),
      .o_px   (w_out[j*W +: W]),
      .o_corr (w_corr[j])
    );
  end

  always_comb begin
    w_ncnt = '0;
    for (int i = 0; i < PX_RATE; i++) begin
      w_ncnt = w_ncnt + {2'b00, w_corr[i] & r_cur_vld};
    end
    w_run_nx = {1'b0, r_run} + {{(CNT_WTH-2){1'b0}}, w_ncnt};
    w_sum    = w_run_nx[CNT_WTH] ? '1 : w_run_nx[CNT_WTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run          <= '0;
      o_frm_corr_cnt <= '0;
    end else if (i_fstr) begin
      r_run          <= '0;
      o_frm_corr_cnt <= w_sum;
    end else begin
      r_run <= w_sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      o_data <= '0;
      o_dvld <= 1'b0;
      o_hstr <= 1'b0;
      o_hend <= 1'b0;
    end else begin
      o_dvld <= r_cur_vld;
      o_hstr <= r_cur_vld & r_cur_hstr;
      o_hend <= r_cur_vld & r_cur_hend;
      if (r_cur_vld) begin
        o_data <= w_out;
      end
    end
  end

endmodule
